if_fetch_queue: RTL

Instruction fetch queue between the program-counter/instruction-memory fetch path and the decode stage. It buffers up to DEPTH fetched (PC, instruction) pairs in FIFO order and decouples fetch from decode stalls. Its `in_ready` drives the PC register's write enable, so the PC advances only when an entry is accepted. A single-cycle flush discards all buffered entries on a branch or jump redirect.

---
 rtl/if_fetch_queue.sv | 45 ++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: FIFO of fetched (pc, instr) pairs between fetch and decode, with single-cycle flush
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [63:0] mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic notEmpty, push, pop;
    always_comb begin
        notEmpty = count != '0;
        in_ready = !reset && !flush && (count != CW'(DEPTH));
        out_valid = !flush && notEmpty;
        out_pc = notEmpty ? mem[rp][63:32] : 32'h0;
        out_instr = notEmpty ? mem[rp][31:0] : 32'h0;
        push = in_valid && in_ready;
        pop = out_valid && out_ready;
    end
    // push is already suppressed during reset and flush, so storage needs no reset
    always_ff @(posedge clk)
        if (push) mem[wp] <= {in_pc, in_instr};
    always_ff @(posedge clk)
        if (reset || flush) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
endmodule
